mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit downstream of the register file: consumes read_data1/read_data2
//  as operand_a/operand_b and executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.

---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 115 +++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/busy/done handshake, MTHI/MTLO strobes and HI/LO result bus of the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, mt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, mt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: one-bit-per-cycle MULT/MULTU/DIV/DIVU into HI/LO with start/busy/done and MTHI/MTLO.
// MDU_SIGNED_EN enables signed MULT/DIV; without it op[0] is ignored.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_div;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_accept = bus.start && !r_busy;
    assign w_last   = r_cnt == CW'(WIDTH - 1);

    // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
    assign w_step  = r_div ? (w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                             : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                           : (r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                       : {1'b0, r_acc[2*WIDTH-1:1]});

`ifdef MDU_SIGNED_EN
    logic w_sa;
    logic w_sb;
    logic r_neg_hi;
    logic r_neg_lo;

    assign w_sa    = bus.op[0] && bus.operand_a[WIDTH-1];
    assign w_sb    = bus.op[0] && bus.operand_b[WIDTH-1];
    assign w_mag_a = w_sa ? -bus.operand_a : bus.operand_a;
    assign w_mag_b = w_sb ? -bus.operand_b : bus.operand_b;
    assign w_res   = r_div ? {r_neg_hi ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH],
                              r_neg_lo ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0]}
                           : (r_neg_lo ? -w_step : w_step);

    // Divide by zero keeps the all-ones quotient; the remainder sign restores operand_a
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
        end else if (w_accept) begin
            r_neg_hi <= bus.op[1] && w_sa;
            r_neg_lo <= (w_sa ^ w_sb) && !(bus.op[1] && bus.operand_b == '0);
        end
    end
`else
    assign w_mag_a = bus.operand_a;
    assign w_mag_b = bus.operand_b;
    assign w_res   = w_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div   <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy && bus.hi_we) r_hi <= bus.mt_data;
            if (!r_busy && bus.lo_we) r_lo <= bus.mt_data;
            if (w_accept) begin
                r_state <= RUN;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_div   <= bus.op[1];
                r_acc   <= {{WIDTH{1'b0}}, bus.op[1] ? w_mag_a : w_mag_b};
                r_b     <= bus.op[1] ? w_mag_b : w_mag_a;
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_hi    <= w_res[2*WIDTH-1:WIDTH];
                    r_lo    <= w_res[WIDTH-1:0];
                end
            end else if (r_state == DONE) begin
                r_state <= IDLE;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed stimulus with an expected-result queue popped by a done monitor.
module tb_mult_div_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_push = 0;
    logic [63:0] exp_q[$];

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign- or zero-extended 64-bit values
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        longint sa, sb, q, r, p;
`ifdef MDU_SIGNED_EN
        sgn = op[0];
`else
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!op[1]) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            check("done_with_busy", {63'b0, bus.busy}, 64'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done with hi=%h lo=%h, expected no pending op", bus.hi, bus.lo);
            end else begin
                check("result_hi_lo", {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [63:0] exp);
        bus.start = 1'b1;
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        if (push) begin
            exp_q.push_back(exp);
            n_push++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
    endtask

    task automatic wait_done(output int bc);
        bit seen;
        seen = 1'b0;
        bc = 0;
        for (int i = 0; i < WIDTH + 8; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) bc++;
            @(negedge clk);
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, expected a done pulse", WIDTH + 8);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int bc;
        drive_op(op, a, b, 1'b1, exp);
        wait_done(bc);
        check("busy_cycles", 64'(bc), 64'(WIDTH));
    endtask

    initial begin
        int bc;
        int saved;
        logic [1:0] op;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.mt_data = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'b0, bus.busy}, 64'd0);
        check("reset_done", {63'b0, bus.done}, 64'd0);
        check("reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.mt_data = 32'h1234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.mt_data = 32'h5678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mthi_mtlo", {bus.hi, bus.lo}, 64'h00001234_00005678);
        drive_op(2'b10, 32'd1000, 32'd7, 1'b1, {32'd6, 32'd142});
        repeat (3) @(negedge clk);
        bus.lo_we = 1'b1;
        bus.mt_data = 32'hDEAD;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("hold_mid_busy", {bus.hi, bus.lo}, 64'h00001234_00005678);
        wait_done(bc);
        check("busy_cycles_mtlo", 64'(bc), 64'(WIDTH - 4));
        @(negedge clk);
        check("hold_after_done", {bus.hi, bus.lo}, {32'd6, 32'd142});
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
`ifdef MDU_SIGNED_EN
        run_op(2'b01, -32'sd3, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
        run_op(2'b11, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_op(2'b11, -32'sd9, 32'd0, 64'hFFFFFFF7_FFFFFFFF);
`else
        run_op(2'b01, -32'sd3, 32'd7, 64'h00000006_FFFFFFEB);
        run_op(2'b11, -32'sd7, 32'd2, 64'h00000001_7FFFFFFC);
`endif
        run_op(2'b10, 32'd100, 32'd0, 64'h00000064_FFFFFFFF);
        drive_op(2'b00, 32'd1234, 32'd5678, 1'b1, 64'd7006652);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.operand_a = 32'd99;
        bus.operand_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc);
        check("busy_cycles_restart", 64'(bc), 64'(WIDTH - 5));
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.mt_data = 32'hABCD;
        drive_op(2'b00, 32'd3, 32'd4, 1'b1, 64'd12);
        bus.hi_we = 1'b0;
        check("mthi_with_start", {32'b0, bus.hi}, 64'h0000ABCD);
        wait_done(bc);
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op(op, a, b, model(op, a, b));
        end
        @(negedge clk);
        drive_op(2'b00, 32'd5, 32'd5, 1'b0, 64'd0);
        repeat (9) @(negedge clk);
        saved = n_done;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_hi_lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 8) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(saved));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_push));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
